// File: rtl/enokida_trace_dispatcher_pkg.sv
// Shared types and constants for the Enokida trace dispatcher slice.
// Widths of the repository entry are fixed here and must match the repository build.
package enokida_trace_dispatcher_pkg;

  localparam int TRACE_ENTRIES = 16;
  localparam int CACHE_BLOCKS  = 8;
  localparam int TRACE_IDX_W   = $clog2(TRACE_ENTRIES);
  localparam int CACHE_BLK_W   = $clog2(CACHE_BLOCKS);
  localparam int REPO_ADDR_W   = 16;
  localparam int REPO_INSTR_W  = 32;

  localparam logic [6:0] STORE_OPCODE = 7'b0100011;

  typedef struct packed {
    logic [REPO_ADDR_W-1:0]  mem_addr;
    logic [REPO_INSTR_W-1:0] instruction;
  } trace_repo_data_entry;

  typedef logic [2:0] dispatcher_state_t;

  localparam dispatcher_state_t S_IDLE       = 3'd0;
  localparam dispatcher_state_t S_REQ        = 3'd1;
  localparam dispatcher_state_t S_CACHE      = 3'd2;
  localparam dispatcher_state_t S_CACHE_WAIT = 3'd3;
  localparam dispatcher_state_t S_MARK       = 3'd4;

  typedef struct packed {
    logic [TRACE_IDX_W-1:0] index;
    logic [CACHE_BLK_W-1:0] block;
    logic [REPO_ADDR_W-1:0] addr;
    logic                   processing_flag;
    logic                   mem_trace_flag;
  } mark_req_t;

  function automatic logic is_store(input logic [6:0] opcode);
    return opcode == STORE_OPCODE;
  endfunction

endpackage

// File: rtl/enokida_mark_done_arbiter.sv
// Two-requester fixed-priority owner of the repository mark-done handshake.
// Requester 0 (core commit) beats requester 1 (dispatcher); fields are frozen at grant.
module enokida_mark_done_arbiter
  import enokida_trace_dispatcher_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  mark_req_t  commit_i,
  input  mark_req_t  disp_i,
  input  logic       ack_valid_i,
  output logic       mark_done_o,
  output mark_req_t  fields_o,
  output logic [1:0] grant_o,
  output logic [1:0] ack_o
);

  logic      mark_done_q;
  logic      owner_q;
  mark_req_t fields_q;

  // A grant is only taken from idle, so the cycle after an ack is always a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mark_done_q <= 1'b0;
      owner_q     <= 1'b0;
      fields_q    <= '0;
    end else if (mark_done_q) begin
      if (ack_valid_i) mark_done_q <= 1'b0;
    end else if (req_i[0]) begin
      mark_done_q <= 1'b1;
      owner_q     <= 1'b0;
      fields_q    <= commit_i;
    end else if (req_i[1]) begin
      mark_done_q <= 1'b1;
      owner_q     <= 1'b1;
      fields_q    <= disp_i;
    end
  end

  assign mark_done_o = mark_done_q;
  assign fields_o    = fields_q;
  assign grant_o     = {mark_done_q & owner_q, mark_done_q & ~owner_q};
  assign ack_o       = grant_o & {2{ack_valid_i}};

endmodule

// File: rtl/enokida_trace_dispatcher.sv
// Replay-phase initiator: fetches trace entries, issues speculative cache accesses,
// and reports dispatcher and core-commit mark-dones plus core index lookups.
module enokida_trace_dispatcher
  import enokida_trace_dispatcher_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int DATA_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  output logic                       trace_req,
  output logic                       cancel,
  input  trace_repo_data_entry       trace_out,
  input  logic [TRACE_IDX_W-1:0]     trace_index_o,
  input  logic                       entry_valid,
  input  logic                       cancelled,
  input  logic                       processing_complete,
  output logic [TRACE_IDX_W-1:0]     index_done,
  output logic [CACHE_BLK_W-1:0]     cache_index,
  output logic                       mark_done,
  output logic                       processing_flag,
  output logic                       mem_trace_flag,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  input  logic                       mark_done_valid,
  output logic [DATA_ADDR_WIDTH-1:0] addr_in,
  output logic                       get_index,
  input  logic [TRACE_IDX_W-1:0]     index_o,
  input  logic                       index_valid,
  output logic                       cache_req,
  output logic                       cache_we,
  output logic [DATA_ADDR_WIDTH-1:0] cache_addr,
  input  logic                       cache_ack,
  input  logic [CACHE_BLK_W-1:0]     cache_block,
  input  logic                       core_req,
  input  logic                       core_done,
  input  logic [DATA_ADDR_WIDTH-1:0] core_addr,
  input  logic [CACHE_BLK_W-1:0]     core_block,
  input  logic [TRACE_IDX_W-1:0]     core_index,
  input  logic                       core_lookup,
  input  logic [DATA_ADDR_WIDTH-1:0] core_lookup_addr,
  output logic [TRACE_IDX_W-1:0]     core_lookup_index,
  output logic                       core_lookup_valid,
  output logic                       done
);

  dispatcher_state_t state_q, state_d;
  logic done_q, done_d;
  logic trace_req_q, cancel_q, cache_req_q, cache_we_q;
  logic entry_store_q;
  logic [DATA_ADDR_WIDTH-1:0] entry_addr_q, cache_addr_q;
  logic [TRACE_IDX_W-1:0]     entry_index_q;
  logic [CACHE_BLK_W-1:0]     block_q;

  logic                       commit_valid_q;
  logic [DATA_ADDR_WIDTH-1:0] commit_addr_q;
  logic [CACHE_BLK_W-1:0]     commit_block_q;
  logic [TRACE_IDX_W-1:0]     commit_index_q;

  logic                       get_index_q, lookup_valid_q;
  logic [DATA_ADDR_WIDTH-1:0] addr_in_q;
  logic [TRACE_IDX_W-1:0]     lookup_index_q;

  logic [1:0] arb_req, arb_grant, arb_ack;
  mark_req_t  commit_fields, disp_fields, mark_fields;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^trace_out.instruction[DATA_DATA_WIDTH-1:7];

  // A granted dispatcher mark must finish even if enable drops, so MARK waits for its ack.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE:
        if (enable && !done_q && !core_req) state_d = S_REQ;
      S_REQ:
        if (!enable)                  state_d = S_IDLE;
        else if (entry_valid)         state_d = S_CACHE;
        else if (cancelled)           state_d = S_IDLE;
        else if (processing_complete) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      S_CACHE:
        state_d = enable ? S_CACHE_WAIT : S_IDLE;
      S_CACHE_WAIT:
        if (!enable)        state_d = S_IDLE;
        else if (cache_ack) state_d = S_MARK;
      S_MARK:
        if (arb_ack[1])                    state_d = S_IDLE;
        else if (!enable && !arb_grant[1]) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      done_q        <= 1'b0;
      trace_req_q   <= 1'b0;
      cancel_q      <= 1'b0;
      cache_req_q   <= 1'b0;
      cache_we_q    <= 1'b0;
      entry_store_q <= 1'b0;
      entry_addr_q  <= '0;
      entry_index_q <= '0;
      cache_addr_q  <= '0;
      block_q       <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      trace_req_q <= (state_d == S_REQ);
      cancel_q    <= (state_d == S_REQ) && core_req;
      cache_req_q <= (state_d == S_CACHE_WAIT);
      cache_we_q  <= (state_d == S_CACHE_WAIT) && entry_store_q;
      if (state_q == S_REQ && state_d == S_CACHE) begin
        entry_addr_q  <= trace_out.mem_addr;
        entry_index_q <= trace_index_o;
        entry_store_q <= is_store(trace_out.instruction[6:0]);
      end
      if (state_q == S_CACHE) cache_addr_q <= entry_addr_q;
      if (state_q == S_CACHE_WAIT && state_d == S_MARK) block_q <= cache_block;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid_q <= 1'b0;
      commit_addr_q  <= '0;
      commit_block_q <= '0;
      commit_index_q <= '0;
    end else if (core_done) begin
      commit_valid_q <= 1'b1;
      commit_addr_q  <= core_addr;
      commit_block_q <= core_block;
      commit_index_q <= core_index;
    end else if (arb_ack[0]) begin
      commit_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      get_index_q    <= 1'b0;
      lookup_valid_q <= 1'b0;
      addr_in_q      <= '0;
      lookup_index_q <= '0;
    end else begin
      lookup_valid_q <= 1'b0;
      if (get_index_q) begin
        if (index_valid) begin
          get_index_q    <= 1'b0;
          lookup_index_q <= index_o;
          lookup_valid_q <= 1'b1;
        end
      end else if (core_lookup) begin
        get_index_q <= 1'b1;
        addr_in_q   <= core_lookup_addr;
      end
    end
  end

  assign commit_fields = {commit_index_q, commit_block_q, commit_addr_q, 2'b00};
  assign disp_fields   = {entry_index_q, block_q, entry_addr_q, 2'b11};
  assign arb_req       = {(state_q == S_MARK) && enable, commit_valid_q};

  enokida_mark_done_arbiter u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (arb_req),
    .commit_i    (commit_fields),
    .disp_i      (disp_fields),
    .ack_valid_i (mark_done_valid),
    .mark_done_o (mark_done),
    .fields_o    (mark_fields),
    .grant_o     (arb_grant),
    .ack_o       (arb_ack)
  );

  assign index_done        = mark_fields.index;
  assign cache_index       = mark_fields.block;
  assign mem_addr          = mark_fields.addr;
  assign processing_flag   = mark_fields.processing_flag;
  assign mem_trace_flag    = mark_fields.mem_trace_flag;
  assign trace_req         = trace_req_q;
  assign cancel            = cancel_q;
  assign cache_req         = cache_req_q;
  assign cache_we          = cache_we_q;
  assign cache_addr        = cache_addr_q;
  assign addr_in           = addr_in_q;
  assign get_index         = get_index_q;
  assign core_lookup_index = lookup_index_q;
  assign core_lookup_valid = lookup_valid_q;
  assign done              = done_q;

  // The core never completes a second access before its first commit is acknowledged.
  a_commit_overrun : assert property (@(posedge clk) disable iff (!rst_n)
    !(core_done && commit_valid_q && !arb_ack[0]));

endmodule
